// File: rtl/window_accumulator_pkg.sv
// Shared types and helpers for the sliding-window accumulator.
package window_accumulator_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef enum logic {
    MODE_SUM  = 1'b0,
    MODE_MEAN = 1'b1
  } mode_e;

  function automatic int sum_width(input int din, input int win);
    return din + $clog2(win);
  endfunction

endpackage

// File: rtl/window_sample_buffer.sv
// Circular sample store; the slot at the write pointer is always the oldest sample.
module window_sample_buffer
  import window_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH_IN = 8,
  parameter int WINDOW        = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic                     i_clr,
  input  logic [DATA_WIDTH_IN-1:0] i_wdata,
  output logic [DATA_WIDTH_IN-1:0] o_old
);

  localparam int PW = $clog2(WINDOW);

  logic [DATA_WIDTH_IN-1:0] r_mem [WINDOW];
  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            w_ptr_nx;

  assign w_ptr_nx = (r_ptr == PW'(WINDOW - 1)) ? '0 : r_ptr + PW'(1);
  assign o_old    = r_mem[r_ptr];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_we) begin
      r_ptr <= w_ptr_nx;
    end
  end

  // Contents are never read before written, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[r_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/window_accumulator.sv
// Sliding-window sum/mean accumulator with one-cycle registered output.
// Define WINDOW_ACCUMULATOR_SAT_EN to saturate instead of truncate on narrow outputs.
module window_accumulator
  import window_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 8,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int WINDOW         = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH_IN-1:0]  i_data,
  input  logic                      i_mode,
  input  logic                      i_clear,
  output logic                      o_valid,
  output logic [DATA_WIDTH_OUT-1:0] o_data,
  output logic                      o_full
);

  localparam int SUM_W = sum_width(DATA_WIDTH_IN, WINDOW);
  localparam int LOG2W = $clog2(WINDOW);
  localparam int CW    = LOG2W + 1;

  if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("WINDOW must be a power of two and at least 2");
  end

  state_e                    r_state;
  state_e                    w_state_nx;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nx;
  logic [SUM_W-1:0]          r_sum;
  logic [SUM_W-1:0]          w_sum_nx;
  logic [SUM_W-1:0]          w_res;
  logic [DATA_WIDTH_OUT-1:0] w_out;
  logic [DATA_WIDTH_IN-1:0]  w_old;
  logic                      w_acc;
  mode_e                     w_mode;

  window_sample_buffer #(
    .DATA_WIDTH_IN (DATA_WIDTH_IN),
    .WINDOW        (WINDOW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_acc),
    .i_clr   (i_clear),
    .i_wdata (i_data),
    .o_old   (w_old)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sum   <= w_sum_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sum_nx   = r_sum;
    w_acc      = 1'b0;
    if (i_clear) begin
      w_state_nx = FILL;
      w_cnt_nx   = '0;
      w_sum_nx   = '0;
    end else if (i_valid) begin
      w_acc = 1'b1;
      unique case (r_state)
        FILL: begin
          w_sum_nx = r_sum + SUM_W'(i_data);
          w_cnt_nx = r_cnt + CW'(1);
          if (r_cnt == CW'(WINDOW - 1)) begin
            w_state_nx = FULL;
          end
        end
        FULL: begin
          // Oldest sample leaves as the new one enters.
          w_sum_nx = r_sum + SUM_W'(i_data) - SUM_W'(w_old);
        end
        default: ;
      endcase
    end
  end

  assign w_mode = mode_e'(i_mode);
  assign w_res  = (w_mode == MODE_MEAN) ? (w_sum_nx >> LOG2W) : w_sum_nx;

`ifdef WINDOW_ACCUMULATOR_SAT_EN
  logic w_over;
  assign w_over = |(w_res >> DATA_WIDTH_OUT);
  assign w_out  = w_over ? '1 : DATA_WIDTH_OUT'(w_res);
`else
  assign w_out  = DATA_WIDTH_OUT'(w_res);
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_full  <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_full  <= 1'b0;
    end else if (i_valid) begin
      o_valid <= 1'b1;
      o_data  <= w_out;
      o_full  <= (w_state_nx == FULL);
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_accumulator.sv
// Directed bench for window_accumulator: default build plus a 9-bit-output instance.
module tb_window_accumulator;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_mode;
  logic        i_clear;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_full;
  logic        n_valid;
  logic [8:0]  n_data;
  logic        n_full;

  int n_cmp = 0;
  int n_bad = 0;

  window_accumulator u_dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .i_clear (i_clear),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_full  (o_full)
  );

  window_accumulator #(.DATA_WIDTH_OUT(9)) u_nar (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .i_clear (i_clear),
    .o_valid (n_valid),
    .o_data  (n_data),
    .o_full  (n_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input int v, input int d, input int f);
    chk({tag, ".valid"}, int'(o_valid), v);
    chk({tag, ".data"}, int'(o_data), d);
    chk({tag, ".full"}, int'(o_full), f);
  endtask

  // Apply inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input int v, input int d, input int m, input int c);
    @(negedge clk);
    i_valid = v[0];
    i_data  = 8'(d);
    i_mode  = m[0];
    i_clear = c[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 1'b0;
    i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_out("reset", 0, 0, 0);
    @(negedge clk);
    i_rst = 1'b1;

    cyc(1, 1, 0, 0); exp_out("sum1", 1, 1, 0);
    cyc(1, 2, 0, 0); exp_out("sum2", 1, 3, 0);
    cyc(1, 3, 0, 0); exp_out("sum3", 1, 6, 0);
    cyc(1, 4, 0, 0); exp_out("sum4", 1, 10, 1);
    cyc(1, 5, 0, 0); exp_out("sum5", 1, 14, 1);
    cyc(1, 6, 0, 0); exp_out("sum6", 1, 18, 1);

    cyc(0, 0, 0, 1); exp_out("clr_a", 0, 0, 0);
    cyc(1, 8, 1, 0); exp_out("mean1", 1, 2, 0);
    cyc(1, 8, 1, 0); exp_out("mean2", 1, 4, 0);
    cyc(1, 8, 1, 0); exp_out("mean3", 1, 6, 0);
    cyc(1, 8, 1, 0); exp_out("mean4", 1, 8, 1);
    cyc(1, 8, 1, 0); exp_out("mean5", 1, 8, 1);

    cyc(0, 0, 0, 1);
    cyc(1, 255, 0, 0); exp_out("max1", 1, 255, 0);
    cyc(1, 255, 0, 0); exp_out("max2", 1, 510, 0);
    cyc(1, 255, 0, 0); exp_out("max3", 1, 765, 0);
    cyc(1, 255, 0, 0); exp_out("max4", 1, 1020, 1);
    cyc(1, 255, 0, 0); exp_out("max5", 1, 1020, 1);
    cyc(1, 255, 0, 0); exp_out("max6", 1, 1020, 1);

    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0); exp_out("pc1", 1, 1, 0);
    cyc(1, 2, 0, 0); exp_out("pc2", 1, 3, 0);
    cyc(1, 3, 0, 0); exp_out("pc3", 1, 6, 0);
    cyc(1, 9, 0, 1); exp_out("clr_v", 0, 0, 0);
    cyc(1, 7, 0, 0); exp_out("after_clr", 1, 7, 0);

    cyc(0, 0, 0, 1);
    cyc(1, 5, 0, 0); exp_out("gap1", 1, 5, 0);
    cyc(0, 0, 0, 0); exp_out("idle1", 0, 5, 0);
    cyc(0, 0, 0, 0); exp_out("idle2", 0, 5, 0);
    cyc(1, 6, 0, 0); exp_out("gap2", 1, 11, 0);
    cyc(0, 0, 1, 0); exp_out("idle3", 0, 11, 0);
    cyc(1, 5, 1, 0); exp_out("mode_sw", 1, 4, 0);
    cyc(1, 0, 0, 0); exp_out("mode_back", 1, 16, 1);

    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, 0);
    end
    exp_out("pre_rst", 1, 4, 1);
    i_valid = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    exp_out("async_rst", 0, 0, 0);
    chk("nar_rst.data", int'(n_data), 0);
    @(negedge clk);
    i_rst = 1'b1;

    cyc(1, 255, 0, 0); chk("nar1", int'(n_data), 255);
    cyc(1, 255, 0, 0);
    cyc(1, 255, 0, 0);
`ifdef WINDOW_ACCUMULATOR_SAT_EN
    chk("nar3", int'(n_data), 511);
`else
    chk("nar3", int'(n_data), 253);
`endif
    cyc(1, 255, 0, 0);
`ifdef WINDOW_ACCUMULATOR_SAT_EN
    chk("nar4", int'(n_data), 511);
`else
    chk("nar4", int'(n_data), 508);
`endif
    chk("nar4.full", int'(n_full), 1);
    chk("nar4.valid", int'(n_valid), 1);
    exp_out("wide4", 1, 1020, 1);

    cyc(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
